// File: rtl/divider_ratio_ctrl_if.sv
// Request/response bundle between divide-ratio requesters and the ratio controller.
// The master side issues requests; the slave (controller) side drives the divider ratio.
interface divider_ratio_ctrl_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_div;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      divide_out;
  logic                  busy;
  logic [IDXW-1:0]       grant_idx;

  modport master (
    output req_valid, req_div,
    input  req_ready, done, divide_out, busy, grant_idx
  );

  modport slave (
    input  req_valid, req_div,
    output req_ready, done, divide_out, busy, grant_idx
  );
endinterface

// File: rtl/divider_ratio_ctrl.sv
// Round-robin owner of the clock divider ratio: ramps divide_out toward the granted
// target in bounded steps, waiting after each step for the divider to settle.
module divider_ratio_ctrl #(
  parameter int NREQ         = 4,
  parameter int WIDTH        = 8,
  parameter int MAX_STEP     = 4,
  parameter int SETTLE_EXTRA = 2,
  parameter int RESET_DIV    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  divider_ratio_ctrl_if.slave  bus
);
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW   = WIDTH + 2;

  localparam logic [WIDTH-1:0] RESET_VAL   = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] STEP_W      = WIDTH'(MAX_STEP);
  localparam logic [31:0]      STEP_U      = 32'(MAX_STEP);
  localparam logic [CW-1:0]    SETTLE_BIAS = CW'(2 + SETTLE_EXTRA);
  localparam logic [IDXW:0]    NREQ_E      = (IDXW+1)'(NREQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_tgt;
  logic [WIDTH-1:0]  r_div;
  logic [CW-1:0]     r_cnt;
  logic [IDXW-1:0]   r_rr_ptr;
  logic [IDXW-1:0]   r_grant_idx;
  logic [NREQ-1:0]   r_req_ready;
  logic [NREQ-1:0]   r_done;
  logic              r_busy;

  state_t            w_state_next;
  logic [WIDTH-1:0]  w_tgt_next;
  logic [WIDTH-1:0]  w_div_next;
  logic [CW-1:0]     w_cnt_next;
  logic [IDXW-1:0]   w_rr_next;
  logic [IDXW-1:0]   w_grant_next;
  logic [NREQ-1:0]   w_ready_next;
  logic [NREQ-1:0]   w_done_next;
  logic              w_busy_next;

  // Requests rotated so that position 0 is the requester rr_ptr points at.
  logic [IDXW-1:0]   w_rot_idx [NREQ];
  logic [NREQ-1:0]   w_rot_req;
  logic              w_found;
  logic [IDXW-1:0]   w_grant;
  logic [IDXW-1:0]   w_rr_after;
  logic [WIDTH-1:0]  w_req_tgt;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_rot
      logic [IDXW:0] w_sum;
      assign w_sum          = {1'b0, r_rr_ptr} + (IDXW+1)'(gi);
      assign w_rot_idx[gi]  = (w_sum >= NREQ_E) ? IDXW'(w_sum - NREQ_E) : IDXW'(w_sum);
      assign w_rot_req[gi]  = bus.req_valid[w_rot_idx[gi]];
    end
  endgenerate

  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot_req[k]) begin
        w_found = 1'b1;
        w_grant = w_rot_idx[k];
      end
    end
  end

  assign w_rr_after = (w_grant == IDXW'(NREQ - 1)) ? '0 : w_grant + IDXW'(1);
  assign w_req_tgt  = bus.req_div[w_grant*WIDTH +: WIDTH];

  // Step toward the target; a full step is only taken when the remaining distance
  // exceeds MAX_STEP, so the add/subtract can never leave the valid ratio range.
  logic             w_up;
  logic [WIDTH-1:0] w_diff;
  logic             w_big;
  logic [WIDTH-1:0] w_step;
  logic [CW-1:0]    w_settle;

  assign w_up     = (r_tgt > r_div);
  assign w_diff   = w_up ? (r_tgt - r_div) : (r_div - r_tgt);
  assign w_big    = (32'(w_diff) > STEP_U);
  assign w_step   = !w_big ? r_tgt : (w_up ? (r_div + STEP_W) : (r_div - STEP_W));
  assign w_settle = CW'(r_div) + CW'(w_step) + SETTLE_BIAS;

  always_comb begin
    w_state_next = r_state;
    w_tgt_next   = r_tgt;
    w_div_next   = r_div;
    w_cnt_next   = r_cnt;
    w_rr_next    = r_rr_ptr;
    w_grant_next = r_grant_idx;
    w_ready_next = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_tgt_next   = w_req_tgt;
          w_grant_next = w_grant;
          w_rr_next    = w_rr_after;
          w_ready_next = NREQ'(1) << w_grant;
          w_state_next = (w_req_tgt == r_div) ? S_DONE : S_STEP;
        end
      end
      S_STEP: begin
        w_div_next   = w_step;
        w_cnt_next   = w_settle;
        w_state_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_state_next = (r_div == r_tgt) ? S_DONE : S_STEP;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    w_done_next = (w_state_next == S_DONE) ? (NREQ'(1) << w_grant_next) : '0;
    w_busy_next = (w_state_next != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_tgt       <= '0;
      r_div       <= RESET_VAL;
      r_cnt       <= '0;
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
      r_req_ready <= '0;
      r_done      <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_tgt       <= w_tgt_next;
      r_div       <= w_div_next;
      r_cnt       <= w_cnt_next;
      r_rr_ptr    <= w_rr_next;
      r_grant_idx <= w_grant_next;
      r_req_ready <= w_ready_next;
      r_done      <= w_done_next;
      r_busy      <= w_busy_next;
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.done       = r_done;
  assign bus.divide_out = r_div;
  assign bus.busy       = r_busy;
  assign bus.grant_idx  = r_grant_idx;

  a_ready_onehot: assert property (@(posedge clk) $onehot0(r_req_ready));
  a_done_onehot:  assert property (@(posedge clk) $onehot0(r_done));
  a_busy_state:   assert property (@(posedge clk) r_busy == (r_state != S_IDLE));
endmodule

// File: tb/tb_divider_ratio_ctrl.sv
// Scoreboard bench: the stimulus side predicts every ready/step/done event with
// its cycle spacing; an independent monitor pops and compares as the DUT emits them.
module tb_divider_ratio_ctrl;
  localparam int NREQ         = 4;
  localparam int WIDTH        = 8;
  localparam int MAX_STEP     = 4;
  localparam int SETTLE_EXTRA = 2;
  localparam int EV_READY     = 0;
  localparam int EV_DIV       = 1;
  localparam int EV_DONE      = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  divider_ratio_ctrl_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  divider_ratio_ctrl #(
    .NREQ(NREQ), .WIDTH(WIDTH), .MAX_STEP(MAX_STEP),
    .SETTLE_EXTRA(SETTLE_EXTRA), .RESET_DIV(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    int kind;
    int val;
    int dly;
    int idx;
  } ev_t;

  ev_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  bit  mon_en = 1'b0;
  int  m_cur = 0;
  int  m_rr = 0;
  int  last_g = 0;
  int  tgt_a [NREQ];

  function automatic void push_ev(int kind, int val, int dly, int idx);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.dly  = dly;
    e.idx  = idx;
    exp_q.push_back(e);
  endfunction

  // One grant: ready, then the ramp values with their spacing, then done.
  function automatic void model_grant(int g, int tgt, bit first);
    int nxt;
    int n;
    int d;
    push_ev(EV_READY, 1 << g, first ? -1 : 2, g);
    m_rr   = (g + 1) % NREQ;
    last_g = g;
    if (tgt == m_cur) begin
      push_ev(EV_DONE, 1 << g, 0, g);
    end else begin
      d = 1;
      n = 0;
      while (m_cur != tgt) begin
        if (tgt > m_cur) nxt = (m_cur + MAX_STEP < tgt) ? m_cur + MAX_STEP : tgt;
        else             nxt = (m_cur - MAX_STEP > tgt) ? m_cur - MAX_STEP : tgt;
        push_ev(EV_DIV, nxt, d, g);
        n     = m_cur + nxt + 2 + SETTLE_EXTRA;
        d     = n + 2;
        m_cur = nxt;
      end
      push_ev(EV_DONE, 1 << g, n + 1, g);
    end
  endfunction

  function automatic void model_batch(logic [NREQ-1:0] mask);
    logic [NREQ-1:0] m;
    bit first;
    int g;
    m = mask;
    first = 1'b1;
    while (m != '0) begin
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && m[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
      end
      model_grant(g, tgt_a[g], first);
      first = 1'b0;
      m[g] = 1'b0;
    end
  endfunction

  function automatic void chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic void fail_now(string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired waiting for DUT", name);
  endfunction

  function automatic void handle(int kind, int val, int dly);
    ev_t e;
    bit ok;
    if (mon_en) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event: kind %0d value %0d after %0d cycles", kind, val, dly);
      end else begin
        e  = exp_q.pop_front();
        ok = (e.kind == kind) && (e.val == val) && (e.dly < 0 || e.dly == dly) &&
             (kind == EV_DIV || int'(bus.grant_idx) == e.idx);
        if (!ok) begin
          miscompares++;
          $display("FAIL event: got kind %0d value %0d delay %0d grant %0d, expected kind %0d value %0d delay %0d grant %0d",
                   kind, val, dly, bus.grant_idx, e.kind, e.val, e.dly, e.idx);
        end else begin
          $display("ok   event kind %0d value %0d delay %0d", kind, val, dly);
        end
      end
    end
  endfunction

  // Monitor: turns DUT outputs into events and hands them to the scoreboard.
  initial begin
    int cyc;
    int last_evt;
    int prev_div;
    cyc = 0;
    last_evt = 0;
    prev_div = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.req_ready != '0) begin
        handle(EV_READY, int'(bus.req_ready), cyc - last_evt);
        last_evt = cyc;
      end
      if (int'(bus.divide_out) != prev_div) begin
        handle(EV_DIV, int'(bus.divide_out), cyc - last_evt);
        prev_div = int'(bus.divide_out);
        last_evt = cyc;
      end
      if (bus.done != '0) begin
        handle(EV_DONE, int'(bus.done), cyc - last_evt);
        last_evt = cyc;
      end
    end
  end

  // Requesters drop valid at the edge after they see their ready pulse.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_ready[i]) bus.req_valid[i] = 1'b0;
    end
  endtask

  task automatic apply_batch(input logic [NREQ-1:0] mask);
    for (int i = 0; i < NREQ; i++) begin
      if (mask[i]) bus.req_div[i*WIDTH +: WIDTH] = WIDTH'(tgt_a[i]);
    end
    bus.req_valid = bus.req_valid | mask;
    model_batch(mask);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 30000) begin
      tick();
      t++;
    end
    if (exp_q.size() != 0) begin
      fail_now("drain");
      exp_q.delete();
    end
    tick();
    tick();
    chk("idle_busy", int'(bus.busy), 0);
    chk("idle_grant_idx", int'(bus.grant_idx), last_g);
  endtask

  task automatic wait_div_change(input int from, input string name);
    int t;
    t = 0;
    while (int'(bus.divide_out) == from && t < 200) begin
      tick();
      t++;
    end
    if (int'(bus.divide_out) == from) fail_now(name);
  endtask

  initial begin
    int dn;
    int r;
    logic [NREQ-1:0] mask;
    bus.req_valid = '0;
    bus.req_div   = '0;
    repeat (3) tick();
    chk("rst_divide_out", int'(bus.divide_out), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_grant_idx", int'(bus.grant_idx), 0);
    chk("rst_req_ready", int'(bus.req_ready), 0);
    chk("rst_done", int'(bus.done), 0);
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // Upward ramp 0 -> 10, then equal target, then downward ramp to 1.
    tgt_a[0] = 10;
    apply_batch(4'b0001);
    wait_drain();
    tgt_a[1] = 10;
    apply_batch(4'b0010);
    wait_drain();
    tgt_a[1] = 1;
    apply_batch(4'b0010);
    wait_drain();

    // A request raised mid-ramp must wait until the current grant completes.
    bus.req_div[0*WIDTH +: WIDTH] = 8'd20;
    bus.req_valid[0] = 1'b1;
    model_grant(0, 20, 1'b1);
    model_grant(2, 7, 1'b0);
    wait_div_change(1, "mid_ramp_step");
    repeat (3) tick();
    bus.req_div[2*WIDTH +: WIDTH] = 8'd7;
    bus.req_valid[2] = 1'b1;
    wait_drain();

    // Reset pulse during SETTLE aborts the grant with no done.
    mon_en = 1'b0;
    bus.req_div[0*WIDTH +: WIDTH] = 8'd30;
    bus.req_valid[0] = 1'b1;
    wait_div_change(7, "abort_step");
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk("abort_divide_out", int'(bus.divide_out), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_grant_idx", int'(bus.grant_idx), 0);
    rst_n = 1'b1;
    dn = 0;
    repeat (80) begin
      tick();
      if (bus.done != '0) dn++;
    end
    chk("abort_no_done", dn, 0);
    m_cur = 0;
    m_rr = 0;
    mon_en = 1'b1;

    // Round robin from a fresh pointer: 0 then 2, then 3 before 1.
    tgt_a[0] = 3;
    tgt_a[2] = 9;
    apply_batch(4'b0101);
    wait_drain();
    tgt_a[1] = 5;
    tgt_a[3] = 2;
    apply_batch(4'b1010);
    wait_drain();

    // Random batches, biased toward zero and equal-to-current targets.
    for (int b = 0; b < 12; b++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        r = int'($urandom_range(0, 3));
        tgt_a[i] = (r == 0) ? 0 : (r == 1) ? m_cur : int'($urandom_range(0, 40));
      end
      apply_batch(mask);
      wait_drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/divider_ratio_ctrl.md
Name: divider_ratio_ctrl

Overview:
- Controller that sits in front of the integer clock divider and owns its `divide_in` ratio input.
- Up to NREQ requesters ask for new divide ratios. The block arbitrates round-robin between them.
- It ramps the ratio toward the granted target in bounded steps. After each step it waits long enough for the divider to adopt the value and emit one full new period.
- It then signals completion to the winning requester.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, divide ratio width; matches the divider's `divide_in`.
- MAX_STEP, 4, largest allowed change of `divide_out` per step (≥1).
- SETTLE_EXTRA, 2, extra guard cycles added to every settle wait.
- RESET_DIV, 0, value of `divide_out` after reset (0 = divider bypass).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset: synchronous, active-low.
- `req_valid`  in  NREQ  bit i: requester i wants a new ratio; held until `req_ready[i]`.
- `req_div`  in  NREQ*WIDTH  slice i = target ratio of requester i; stable while `req_valid[i]`.
- `req_ready`  out  NREQ  one-cycle pulse: request i accepted.
- `done`  out  NREQ  one-cycle pulse: `divide_out` has reached the target of i and settled.
- `divide_out`  out  WIDTH  ratio driven to the divider's `divide_in`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `grant_idx`  out  clog2(NREQ)  index of the current/last granted requester.

Behaviour:
- All outputs registered.
- Reset values: `req_ready`=0, `done`=0, `divide_out`=RESET_DIV, `busy`=0, `grant_idx`=0, state=IDLE, rr_ptr=0, settle counter=0.
- States: IDLE, STEP, SETTLE, DONE.
- IDLE:
  - If any `req_valid`: scan circularly starting at rr_ptr; first set bit wins (g).
  - Latch `tgt`=`req_div[g]`, `grant_idx`=g, rr_ptr=(g+1) mod NREQ.
  - Assert `req_ready[g]` for exactly the next cycle.
  - Next state: DONE if `tgt`==`divide_out`, else STEP.
  - If no request, stay in IDLE.
- STEP (one cycle):
  - next = min(cur+MAX_STEP, tgt) if tgt>cur, else max(cur−MAX_STEP, tgt).
  - Compute in WIDTH+1 bits; never wraps below 0 or above 2^WIDTH−1.
  - `divide_out`<=next.
  - Settle counter <= cur+next+2+SETTLE_EXTRA (width WIDTH+2). This covers the divider waiting for its old count to wrap plus one full new period.
  - Go to SETTLE.
- SETTLE:
  - Counter decrements each cycle; state exits on the cycle it reads 0, so SETTLE occupies N+1 cycles.
  - On exit: DONE if `divide_out`==`tgt`, else STEP.
- DONE (one cycle): `done[grant_idx]`=1, then IDLE.
- Requesters drop `req_valid` at the edge after seeing `req_ready`. A request seen in IDLE is never granted twice, because IDLE is not re-entered before that edge.
- Requests arriving while `busy` are ignored: no `req_ready`, and no `req_valid` is sampled. They are arbitrated on the next IDLE cycle.
- A `req_div` change while waiting (before `req_ready`) is allowed; the value present in the grant cycle is used.
- At most one bit of `req_ready` and of `done` is high in any cycle. `req_ready` and `done` for the same grant never coincide except in the equal-target case, where `req_ready[g]` and `done[g]` are both high in the DONE cycle.
- `divide_out` changes only on STEP cycles; it is never modified in IDLE/SETTLE/DONE.
- Reset asserted mid-operation:
  - On the next edge all state returns to reset values, and `divide_out` goes to RESET_DIV.
  - The in-flight request gets no `done`; the requester must re-request.

Test Plan:
- MAX_STEP=4, SETTLE_EXTRA=2, from reset, `req_valid[0]`, `req_div[0]`=10 → `req_ready[0]` pulse. `divide_out` sequence is 4, 8, 10, with SETTLE lengths 9, 17, 23 cycles. Then a single `done[0]` pulse, `busy`=0.
- After the above, `req_valid[1]` with `req_div[1]`=10 → `req_ready[1]` and `done[1]` in the same cycle, two cycles after the request is seen. `divide_out` stays 10 and no STEP occurs.
- `divide_out`=10, request 1 → `divide_out` 6, 2, 1 with SETTLE lengths 21, 13, 8 cycles. No underflow; `done` asserted once.
- From reset, `req_valid`=4'b0101 held → req0 granted first (`grant_idx`=0), then req2. Then with req1 and req3 pending and rr_ptr=3 → req3 granted before req1.
- Request 0 (`req_div`=20) in flight; `req_valid[2]` asserted during SETTLE → `req_ready[2]` stays low until the cycle after `done[0]`. req2 is then granted.
- `rst_n`=0 for one cycle during SETTLE → next cycle `divide_out`=0, `busy`=0, state IDLE. No `done` pulse ever appears for the aborted request.
